// File: rtl/seven_segment_display_ctrl.sv
// Multiplexed N-digit seven-segment display controller.
// Loads a WIDTH-bit value, signed or unsigned per load, converts it to BCD with a
// bit-serial double-dabble engine, and scans DIGITS common-anode digits.
// The leftmost digit is the sign; the remaining DIGITS-1 digits hold the magnitude.
// Optional macro LEADING_ZERO_BLANK_EN blanks magnitude digits left of the first nonzero digit.
module seven_segment_display_ctrl #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 262144
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  num_in,
  input  logic              signed_mode,
  input  logic              load,
  output logic              busy,
  output logic              overflow,
  output logic [DIGITS-1:0] Anode,
  output logic [6:0]        LED_out
);

  localparam int unsigned MAGD = DIGITS - 1;
  localparam int unsigned NREQ = (WIDTH + 2) / 3;
  localparam int unsigned NNIB = (NREQ > MAGD) ? NREQ : MAGD;
  localparam int unsigned PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW   = $clog2(DIGITS);
  localparam int unsigned CW   = $clog2(WIDTH + 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                 state_q;
  logic [WIDTH-1:0]       mag_q;
  logic [4*NNIB-1:0]      bcd_q;
  logic [4*NNIB-1:0]      bcd_adj;
  logic [4*NNIB+WIDTH-1:0] shifted;
  logic                   neg_q;
  logic [CW-1:0]          bit_cnt_q;
  logic                   hi_nz;
  logic [4*MAGD-1:0]      disp_q;
  logic                   disp_neg_q;
  logic [PW-1:0]          pre_q;
  logic [IW-1:0]          idx_q;
  logic [MAGD-1:0]        lz;
  logic [3:0]             nib;
  logic                   lead_blank;
  logic [DIGITS-1:0]      anode_c;
  logic [6:0]             seg_c;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Double-dabble step: add 3 to nibbles >= 5, then shift the whole chain left by one
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < int'(NNIB); k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    shifted = {bcd_adj, mag_q} << 1;
  end

  // Any scratch nibble beyond the displayable digits means overflow
  always_comb begin
    hi_nz = 1'b0;
    for (int k = int'(MAGD); k < int'(NNIB); k++) begin
      hi_nz = hi_nz | (bcd_q[4*k +: 4] != 4'd0);
    end
  end

  // Conversion FSM with registered busy, overflow and display registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      mag_q      <= '0;
      bcd_q      <= '0;
      neg_q      <= 1'b0;
      bit_cnt_q  <= '0;
      disp_q     <= '0;
      disp_neg_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            mag_q     <= (signed_mode && num_in[WIDTH-1]) ? (~num_in + WIDTH'(1)) : num_in;
            neg_q     <= signed_mode && num_in[WIDTH-1];
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            busy      <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q     <= shifted[4*NNIB+WIDTH-1 : WIDTH];
          mag_q     <= shifted[WIDTH-1:0];
          bit_cnt_q <= bit_cnt_q + CW'(1);
          if (bit_cnt_q == CW'(WIDTH - 1)) state_q <= COMMIT;
        end
        COMMIT: begin
          disp_q     <= bcd_q[4*MAGD-1:0];
          disp_neg_q <= neg_q;
          overflow   <= hi_nz;
          busy       <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Prescaler and scan index
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      idx_q <= '0;
    end else if (pre_q == PW'(PRESCALE - 1)) begin
      pre_q <= '0;
      idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end else begin
      pre_q <= pre_q + PW'(1);
    end
  end

  // Leading-zero mask: lz[k] set when nibble k and all above it are zero (ones digit never)
  always_comb begin
    lz = '0;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic run;
      run = 1'b1;
      for (int k = int'(MAGD) - 1; k > 0; k--) begin
        run   = run && (disp_q[4*k +: 4] == 4'd0);
        lz[k] = run;
      end
    end
`endif
  end

  // Select anode and segment pattern for the current scan index
  always_comb begin
    anode_c    = '1;
    nib        = 4'd0;
    lead_blank = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IW'(i)) anode_c[int'(DIGITS) - 1 - i] = 1'b0;
    end
    for (int k = 0; k < int'(MAGD); k++) begin
      if (idx_q == IW'(int'(DIGITS) - 1 - k)) begin
        nib        = disp_q[4*k +: 4];
        lead_blank = lz[k];
      end
    end
    if (idx_q == '0)     seg_c = disp_neg_q ? SEG_DASH : SEG_BLANK;
    else if (overflow)   seg_c = SEG_DASH;
    else if (lead_blank) seg_c = SEG_BLANK;
    else                 seg_c = seg_decode(nib);
  end

  // Registered pin drivers
  always_ff @(posedge clk) begin
    if (rst) begin
      Anode   <= '1;
      LED_out <= SEG_BLANK;
    end else begin
      Anode   <= anode_c;
      LED_out <= seg_c;
    end
  end

endmodule

// File: tb/tb_seven_segment_display_ctrl.sv
// Bench for seven_segment_display_ctrl: one 4-digit and one 3-digit instance.
module tb_seven_segment_display_ctrl;

  localparam int unsigned PRE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] num_a = '0, num_b = '0;
  logic       sm_a = 1'b0, sm_b = 1'b0, load_a = 1'b0, load_b = 1'b0;
  logic       busy_a, busy_b, ovf_a, ovf_b;
  logic [3:0] anode_a;
  logic [2:0] anode_b;
  logic [6:0] led_a, led_b;

  int checks = 0;
  int errors = 0;

  logic [6:0] cap_seg[8];
  bit         cap_seen[8];
  logic [6:0] exp_seg[8];
  bit         exp_ovf;

  typedef struct {
    logic [7:0] v;
    bit         s;
    bit         neg;
    int         mag;
  } vec_t;

  vec_t tbl[10];

  seven_segment_display_ctrl #(.DIGITS(4), .WIDTH(8), .PRESCALE(PRE)) dut_a (
    .clk(clk), .rst(rst), .num_in(num_a), .signed_mode(sm_a), .load(load_a),
    .busy(busy_a), .overflow(ovf_a), .Anode(anode_a), .LED_out(led_a));

  seven_segment_display_ctrl #(.DIGITS(3), .WIDTH(8), .PRESCALE(PRE)) dut_b (
    .clk(clk), .rst(rst), .num_in(num_b), .signed_mode(sm_b), .load(load_b),
    .busy(busy_b), .overflow(ovf_b), .Anode(anode_b), .LED_out(led_b));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d (%b) required=%0d (%b)", name, act, act[6:0], req, req[6:0]);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected digit contents from the decimal value, digit count and sign
  task automatic model(input int nd, input int mag, input bit neg);
    int lim;
    lim = 1;
    for (int i = 0; i < nd - 1; i++) lim = lim * 10;
    exp_ovf    = (mag >= lim);
    exp_seg[0] = neg ? 7'b1111110 : 7'b1111111;
    for (int p = 1; p < nd; p++) begin
      int place;
      int pw;
      int d;
      place = nd - 1 - p;
      pw = 1;
      for (int i = 0; i < place; i++) pw = pw * 10;
      d = (mag / pw) % 10;
      if (exp_ovf) exp_seg[p] = 7'b1111110;
`ifdef LEADING_ZERO_BLANK_EN
      else if (place > 0 && mag < pw) exp_seg[p] = 7'b1111111;
`endif
      else exp_seg[p] = seg_of(d);
    end
  endtask

  function automatic bit cur_busy(input int sel);
    return (sel != 0) ? busy_b : busy_a;
  endfunction

  // Observe one full scan and record each digit's segments
  task automatic capture(input int sel);
    int nd;
    int bad;
    int lows;
    logic [7:0] an;
    logic [6:0] led;
    nd  = (sel != 0) ? 3 : 4;
    bad = 0;
    for (int i = 0; i < 8; i++) cap_seen[i] = 1'b0;
    for (int c = 0; c < nd * int'(PRE) + 4; c++) begin
      @(negedge clk);
      an   = (sel != 0) ? {5'h1f, anode_b} : {4'hf, anode_a};
      led  = (sel != 0) ? led_b : led_a;
      lows = 0;
      for (int i = 0; i < nd; i++) begin
        if (!an[i]) begin
          lows++;
          cap_seg[nd-1-i]  = led;
          cap_seen[nd-1-i] = 1'b1;
        end
      end
      if (lows != 1) bad++;
    end
    chk("anode_onehot_violations", bad, 0);
    for (int i = 0; i < nd; i++) if (!cap_seen[i]) bad++;
    chk("scan_digits_missing", bad, 0);
  endtask

  task automatic check_disp(input int sel, input string name);
    int nd;
    nd = (sel != 0) ? 3 : 4;
    for (int p = 0; p < nd; p++) chk($sformatf("%s_digit%0d", name, p), int'(cap_seg[p]), int'(exp_seg[p]));
    chk({name, "_overflow"}, int'((sel != 0) ? ovf_b : ovf_a), int'(exp_ovf));
  endtask

  task automatic do_load(input int sel, input logic [7:0] v, input bit s, input string name);
    int n;
    n = 0;
    @(negedge clk);
    if (sel != 0) begin num_b = v; sm_b = s; load_b = 1'b1; end
    else          begin num_a = v; sm_a = s; load_a = 1'b1; end
    @(negedge clk);
    load_a = 1'b0;
    load_b = 1'b0;
    while (cur_busy(sel) && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_busy_cycles"}, n, 9);
  endtask

  task automatic run_vec(input int sel, input logic [7:0] v, input bit s, input string name);
    bit neg;
    int mag;
    neg = s && v[7];
    mag = neg ? 256 - int'(v) : int'(v);
    do_load(sel, v, s, name);
    model((sel != 0) ? 3 : 4, mag, neg);
    capture(sel);
    check_disp(sel, name);
  endtask

  initial begin
    int n;
    tbl[0] = '{v: 8'hF6, s: 1'b1, neg: 1'b1, mag: 10};
    tbl[1] = '{v: 8'h80, s: 1'b1, neg: 1'b1, mag: 128};
    tbl[2] = '{v: 8'h80, s: 1'b0, neg: 1'b0, mag: 128};
    tbl[3] = '{v: 8'h7F, s: 1'b1, neg: 1'b0, mag: 127};
    tbl[4] = '{v: 8'hFF, s: 1'b1, neg: 1'b1, mag: 1};
    tbl[5] = '{v: 8'h00, s: 1'b0, neg: 1'b0, mag: 0};
    tbl[6] = '{v: 8'h05, s: 1'b0, neg: 1'b0, mag: 5};
    tbl[7] = '{v: 8'h63, s: 1'b0, neg: 1'b0, mag: 99};
    tbl[8] = '{v: 8'hFF, s: 1'b0, neg: 1'b0, mag: 255};
    tbl[9] = '{v: 8'h9C, s: 1'b1, neg: 1'b1, mag: 100};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_anode_a", int'(anode_a), 15);
    chk("rst_anode_b", int'(anode_b), 7);
    chk("rst_led_a", int'(led_a), 127);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_overflow_a", int'(ovf_a), 0);
    rst = 1'b0;
    model(4, 0, 1'b0);
    capture(0);
    check_disp(0, "reset_scan_a");
    model(3, 0, 1'b0);
    capture(1);
    check_disp(1, "reset_scan_b");

    // Directed table on the 4-digit instance
    for (int i = 0; i < 10; i++) begin
      do_load(0, tbl[i].v, tbl[i].s, $sformatf("tbl%0d", i));
      model(4, tbl[i].mag, tbl[i].neg);
      capture(0);
      check_disp(0, $sformatf("tbl%0d", i));
    end

    // 3-digit instance: overflow set, then cleared
    do_load(1, 8'hFF, 1'b0, "b_255");
    model(3, 255, 1'b0);
    capture(1);
    check_disp(1, "b_255");
    do_load(1, 8'd99, 1'b0, "b_99");
    model(3, 99, 1'b0);
    capture(1);
    check_disp(1, "b_99");
    run_vec(1, 8'h80, 1'b1, "b_m128");

    // Load while busy is ignored
    @(negedge clk);
    num_a = 8'd42; sm_a = 1'b0; load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    n = 0;
    while (busy_a && n < 40) begin
      n++;
      if (n == 3) begin num_a = 8'd7; load_a = 1'b1; end
      else load_a = 1'b0;
      @(negedge clk);
    end
    load_a = 1'b0;
    chk("busy_load_busy_cycles", n, 9);
    model(4, 42, 1'b0);
    capture(0);
    check_disp(0, "busy_load");
    chk("busy_load_no_requeue", int'(busy_a), 0);

    // Reset in the middle of a conversion
    @(negedge clk);
    num_a = 8'd123; sm_a = 1'b0; load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("midshift_busy", int'(busy_a), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midshift_rst_busy", int'(busy_a), 0);
    chk("midshift_rst_overflow", int'(ovf_a), 0);
    model(4, 0, 1'b0);
    capture(0);
    check_disp(0, "midshift_rst");
    run_vec(0, 8'd123, 1'b0, "after_rst");

    // Random values against the model
    for (int i = 0; i < 16; i++)
      run_vec(0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), $sformatf("rnd_a%0d", i));
    for (int i = 0; i < 6; i++)
      run_vec(1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), $sformatf("rnd_b%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_display_ctrl.md
Name: seven_segment_display_ctrl

Overview:
- Parametrised multiplexed N-digit seven-segment display controller. Successor to the fixed 4-digit, 8-bit signed driver.
- Accepts a WIDTH-bit value through a load handshake, with signed or unsigned interpretation selected per load.
- Converts the value to BCD with a sequential shift-add-3 (double-dabble) engine, one bit per cycle.
- Scans DIGITS common-anode digits at a programmable rate: leftmost digit carries the sign, the rest carry the magnitude, plus overflow indication. Sits between datapath result registers and board display pins.

Parameters:
- DIGITS, 4: total digit positions; leftmost is sign, DIGITS-1 magnitude digits (range 2..8).
- WIDTH, 8: input value width in bits (range 4..32).
- PRESCALE, 262144: clk cycles each digit stays active before the scan advances (>=1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- num_in  in  WIDTH  value to display; sampled only on an accepted load.
- signed_mode  in  1  1 = num_in is two's complement, 0 = unsigned; sampled with num_in.
- load  in  1  request to convert and display num_in.
- busy  out  1  conversion in progress; load ignored while high.
- overflow  out  1  displayed magnitude does not fit in DIGITS-1 decimal digits.
- Anode  out  DIGITS  digit enables, active low; Anode[DIGITS-1] = leftmost (sign).
- LED_out  out  7  segments {a,b,c,d,e,f,g}, active low (0 = lit).

Behaviour:
- Reset (rst=1 at an edge):
  - Anode=all 1s, LED_out=7'b1111111, busy=0, overflow=0.
  - Display registers = value 0, positive; scan index=0; prescaler=0.
  - Reset mid-conversion aborts it; the display shows 0.
- FSM states:
  - IDLE: load=1 accepts. Captures magnitude = (signed_mode && num_in[WIDTH-1]) ? -num_in : num_in in WIDTH bits unsigned, and the negative flag. Clears BCD scratch; next state SHIFT.
  - SHIFT: exactly WIDTH cycles. Each cycle adds 3 to every BCD nibble >=5, then shifts one magnitude bit in, MSB first.
  - COMMIT: 1 cycle. Copies the low DIGITS-1 BCD nibbles and the sign to the display registers. Sets overflow=1 if any higher scratch nibble is nonzero; next state IDLE.
- busy: high from the edge after load acceptance through COMMIT, i.e. WIDTH+1 cycles. Display and overflow change atomically at the COMMIT edge; the old value is shown until then.
- load while busy: ignored, no queuing.
- Most-negative input (e.g. 8'h80 signed): magnitude 128, displayed correctly.
- Scan:
  - Prescaler counts 0..PRESCALE-1. On wrap, scan index advances 0..DIGITS-1 and wraps to 0.
  - Index i drives Anode[DIGITS-1-i] low and all others high; exactly one anode is low at any time after reset.
- Segment content:
  - Index 0 (sign digit): 7'b1111110 (minus) if negative, else 7'b1111111 (blank).
  - Other indices: BCD digit decode 0..9 per the standard table (0=7'b0000001, 1=7'b1001111, ... 9=7'b0000100).
  - If overflow=1, every magnitude digit shows 7'b1111110 (dash); the sign digit still reflects the sign.
- Anode and LED_out are registered: they reflect the scan index and display registers one cycle late, with no glitches between digits.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: magnitude digits left of the most significant nonzero digit show blank (7'b1111111). The ones digit is never blanked (value 0 shows a single "0"). The sign stays on the leftmost digit. Overflow dashes are unaffected.
- Undefined: all magnitude digits are shown, including leading zeros.

Test Plan (DIGITS=4, WIDTH=8, PRESCALE=4 unless noted):
1. Reset released -> Anode=1111 and LED_out=1111111 during reset, busy=0. Then the scan cycles 0111,1011,1101,1110 every 4 cycles with blank,0,0,0.
2. load with num_in=8'hF6, signed_mode=1 -> busy high 9 cycles. Then digits: 1111110, 0000001, 1001111, 0000001 ("-010"); overflow=0.
3. num_in=8'h80: signed -> "-128"; unsigned -> blank,"1","2","8" (1001111, 0010010, 0000000).
4. DIGITS=3, unsigned num_in=8'hFF -> overflow=1; digits blank, dash, dash. Then load 8'd99 -> overflow=0, blank,"9","9".
5. Second load asserted during busy -> ignored, first value displayed. rst pulsed mid-SHIFT -> busy=0, display 0.
6. LEADING_ZERO_BLANK_EN defined, unsigned 8'd5 -> blank, blank, blank, 0100100; 8'd0 -> blank, blank, blank, 0000001.
